// File: rtl/fetch_sequencer.sv
// fetch_sequencer: owns the program counter and sequences instruction fetch.
// One request at a time goes to instruction memory over a req/ack handshake.
// Each fetched word goes to decode over a valid/ready handshake.
// Redirects and traps squash wrong-path fetches; a trap wins over a redirect.
// Optional macro FETCH_PERF_CNT_EN adds the stall and flush performance counters.
// Without it, both counter ports are tied to zero.
module fetch_sequencer #(
    parameter int unsigned           XLEN         = 32,
    parameter logic [XLEN-1:0]       RESET_VECTOR = '0,
    parameter logic [XLEN-1:0]       PC_STEP      = XLEN'(1)
) (
    input  logic            clk,
    input  logic            reset_n,
    input  logic            stall_i,
    input  logic            redirect_valid,
    input  logic [XLEN-1:0] redirect_target,
    input  logic            trap_valid,
    input  logic [XLEN-1:0] trap_vector,
    output logic            imem_req,
    output logic [XLEN-1:0] imem_addr,
    input  logic            imem_ack,
    input  logic [XLEN-1:0] imem_rdata,
    output logic            fetch_valid,
    output logic [XLEN-1:0] fetch_pc,
    output logic [XLEN-1:0] fetch_instr,
    input  logic            fetch_ready,
    output logic [31:0]     perf_stall_cnt,
    output logic [31:0]     perf_flush_cnt
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        REQ   = 2'd1,
        HOLD  = 2'd2,
        FLUSH = 2'd3
    } state_t;

    state_t          state_q, state_d;
    logic [XLEN-1:0] pc_q, pc_d;
    logic [XLEN-1:0] addr_q;
    logic            fv_q, fv_d;
    logic [XLEN-1:0] fpc_q, fpc_d;
    logic [XLEN-1:0] finstr_q, finstr_d;

    logic            redir;
    logic [XLEN-1:0] redir_pc;

    assign redir    = trap_valid | redirect_valid;
    assign redir_pc = trap_valid ? trap_vector : redirect_target;

    // The request line is driven straight from the state, so stall_i cannot drop it.
    // FLUSH keeps presenting the address captured while in REQ, because pc has moved on.
    assign imem_req    = (state_q == REQ) || (state_q == FLUSH);
    assign imem_addr   = (state_q == FLUSH) ? addr_q : pc_q;
    assign fetch_valid = fv_q;
    assign fetch_pc    = fpc_q;
    assign fetch_instr = finstr_q;

    // Next-state, pc and decode-side register update.
    always_comb begin
        state_d  = state_q;
        pc_d     = pc_q;
        fv_d     = fv_q;
        fpc_d    = fpc_q;
        finstr_d = finstr_q;
        unique case (state_q)
            IDLE: begin
                if (redir) begin
                    pc_d = redir_pc;
                    fv_d = 1'b0;
                end
                if (!stall_i) state_d = REQ;
            end
            REQ: begin
                if (redir) begin
                    // The memory transaction must still complete.
                    // Any data returning with it belongs to the wrong path.
                    pc_d    = redir_pc;
                    fv_d    = 1'b0;
                    state_d = imem_ack ? REQ : FLUSH;
                end else if (imem_ack) begin
                    finstr_d = imem_rdata;
                    fpc_d    = pc_q;
                    fv_d     = 1'b1;
                    pc_d     = pc_q + PC_STEP;
                    state_d  = HOLD;
                end
            end
            HOLD: begin
                if (redir) begin
                    // The held instruction is dropped even if decode takes it this cycle.
                    pc_d    = redir_pc;
                    fv_d    = 1'b0;
                    state_d = stall_i ? IDLE : REQ;
                end else if (fetch_ready) begin
                    // Stay in HOLD until decode takes the word, so no instruction is lost.
                    fv_d    = 1'b0;
                    state_d = stall_i ? IDLE : REQ;
                end
            end
            FLUSH: begin
                if (redir) begin
                    pc_d = redir_pc;
                    fv_d = 1'b0;
                end
                if (imem_ack) state_d = REQ;
            end
            default: state_d = IDLE;
        endcase
    end

    // State and datapath registers, synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state_q  <= IDLE;
            pc_q     <= RESET_VECTOR;
            addr_q   <= RESET_VECTOR;
            fv_q     <= 1'b0;
            fpc_q    <= '0;
            finstr_q <= '0;
        end else begin
            state_q  <= state_d;
            pc_q     <= pc_d;
            fv_q     <= fv_d;
            fpc_q    <= fpc_d;
            finstr_q <= finstr_d;
            if (state_q == REQ) addr_q <= pc_q;
        end
    end

`ifdef FETCH_PERF_CNT_EN
    logic [31:0] stall_cnt_q;
    logic [31:0] flush_cnt_q;
    logic        flush_evt;

    // An ack is discarded when it completes a FLUSH, or when it coincides with a redirect in REQ.
    assign flush_evt = imem_ack && ((state_q == FLUSH) || ((state_q == REQ) && redir));

    // Free-running, wrapping event counters.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            stall_cnt_q <= '0;
            flush_cnt_q <= '0;
        end else begin
            if (stall_i)   stall_cnt_q <= stall_cnt_q + 32'd1;
            if (flush_evt) flush_cnt_q <= flush_cnt_q + 32'd1;
        end
    end

    assign perf_stall_cnt = stall_cnt_q;
    assign perf_flush_cnt = flush_cnt_q;
`else
    assign perf_stall_cnt = '0;
    assign perf_flush_cnt = '0;
`endif

endmodule

// File: tb/tb_fetch_sequencer.sv
// Directed testbench for fetch_sequencer.
// Inputs are driven 1 time unit after each rising edge.
// Outputs are sampled at the same point.
`timescale 1ns/1ps
module tb_fetch_sequencer;

    logic        clk = 1'b0;
    logic        reset_n;
    logic        stall_i;
    logic        redirect_valid;
    logic [31:0] redirect_target;
    logic        trap_valid;
    logic [31:0] trap_vector;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_ack;
    logic [31:0] imem_rdata;
    logic        fetch_valid;
    logic [31:0] fetch_pc;
    logic [31:0] fetch_instr;
    logic        fetch_ready;
    logic [31:0] perf_stall_cnt;
    logic [31:0] perf_flush_cnt;

    int n_vec = 0;
    int n_err = 0;

    fetch_sequencer dut (
        .clk             (clk),
        .reset_n         (reset_n),
        .stall_i         (stall_i),
        .redirect_valid  (redirect_valid),
        .redirect_target (redirect_target),
        .trap_valid      (trap_valid),
        .trap_vector     (trap_vector),
        .imem_req        (imem_req),
        .imem_addr       (imem_addr),
        .imem_ack        (imem_ack),
        .imem_rdata      (imem_rdata),
        .fetch_valid     (fetch_valid),
        .fetch_pc        (fetch_pc),
        .fetch_instr     (fetch_instr),
        .fetch_ready     (fetch_ready),
        .perf_stall_cnt  (perf_stall_cnt),
        .perf_flush_cnt  (perf_flush_cnt)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        reset_n = 1'b0; stall_i = 1'b0; redirect_valid = 1'b0; redirect_target = '0;
        trap_valid = 1'b0; trap_vector = '0; imem_ack = 1'b0; imem_rdata = '0; fetch_ready = 1'b0;
        tick(); tick();
        n_vec++; if (imem_req !== 1'b0)   begin n_err++; $display("FAIL reset_req got %b want 0", imem_req); end
        n_vec++; if (fetch_valid !== 1'b0) begin n_err++; $display("FAIL reset_valid got %b want 0", fetch_valid); end
        n_vec++; if (fetch_pc !== 32'h0)   begin n_err++; $display("FAIL reset_pc got %h want 0", fetch_pc); end
        n_vec++; if (fetch_instr !== 32'h0) begin n_err++; $display("FAIL reset_instr got %h want 0", fetch_instr); end
        n_vec++; if (perf_stall_cnt !== 32'h0 || perf_flush_cnt !== 32'h0) begin
            n_err++; $display("FAIL reset_perf got %h/%h want 0/0", perf_stall_cnt, perf_flush_cnt); end
        reset_n = 1'b1;
        tick();
        n_vec++; if (imem_req !== 1'b1 || imem_addr !== 32'h0) begin
            n_err++; $display("FAIL first_req got req=%b addr=%h want 1/0", imem_req, imem_addr); end
    endtask

    task automatic test_sequential();
        for (int i = 0; i < 4; i++) begin
            n_vec++; if (imem_req !== 1'b1 || imem_addr !== i) begin
                n_err++; $display("FAIL seq_addr%0d got req=%b addr=%h want 1/%h", i, imem_req, imem_addr, i); end
            imem_ack = 1'b1; imem_rdata = 32'hA000_0000 + i;
            tick();
            imem_ack = 1'b0; fetch_ready = 1'b1;
            n_vec++; if (fetch_valid !== 1'b1 || fetch_pc !== i || fetch_instr !== 32'hA000_0000 + i || imem_req !== 1'b0) begin
                n_err++; $display("FAIL seq_out%0d got v=%b pc=%h instr=%h req=%b", i, fetch_valid, fetch_pc, fetch_instr, imem_req); end
            tick();
            fetch_ready = 1'b0;
        end
    endtask

    task automatic test_delayed_ack();
        for (int c = 0; c < 4; c++) begin
            n_vec++; if (imem_req !== 1'b1 || imem_addr !== 32'd4) begin
                n_err++; $display("FAIL wait_cycle%0d got req=%b addr=%h want 1/4", c, imem_req, imem_addr); end
            if (c < 3) tick();
        end
        imem_ack = 1'b1; imem_rdata = 32'hBEEF_0004;
        tick();
        imem_ack = 1'b0; fetch_ready = 1'b1;
        n_vec++; if (fetch_valid !== 1'b1 || fetch_pc !== 32'd4 || fetch_instr !== 32'hBEEF_0004) begin
            n_err++; $display("FAIL wait_out got v=%b pc=%h instr=%h", fetch_valid, fetch_pc, fetch_instr); end
        tick();
        fetch_ready = 1'b0;
    endtask

    task automatic test_redirect_flush();
        redirect_valid = 1'b1; redirect_target = 32'h40;
        tick();
        redirect_valid = 1'b0;
        n_vec++; if (imem_req !== 1'b1 || imem_addr !== 32'd5 || fetch_valid !== 1'b0) begin
            n_err++; $display("FAIL flush_hold got req=%b addr=%h v=%b want 1/5/0", imem_req, imem_addr, fetch_valid); end
        tick();
        n_vec++; if (imem_req !== 1'b1 || imem_addr !== 32'd5) begin
            n_err++; $display("FAIL flush_wait got req=%b addr=%h want 1/5", imem_req, imem_addr); end
        imem_ack = 1'b1; imem_rdata = 32'hDEAD_DEAD;
        tick();
        imem_ack = 1'b0;
        n_vec++; if (fetch_valid !== 1'b0 || imem_req !== 1'b1 || imem_addr !== 32'h40) begin
            n_err++; $display("FAIL flush_done got v=%b req=%b addr=%h want 0/1/40", fetch_valid, imem_req, imem_addr); end
    endtask

    task automatic test_trap_priority();
        trap_valid = 1'b1; trap_vector = 32'h100;
        redirect_valid = 1'b1; redirect_target = 32'h40;
        imem_ack = 1'b1; imem_rdata = 32'h1111_1111;
        tick();
        trap_valid = 1'b0; redirect_valid = 1'b0; imem_ack = 1'b0;
        n_vec++; if (fetch_valid !== 1'b0 || imem_req !== 1'b1 || imem_addr !== 32'h100) begin
            n_err++; $display("FAIL trap_prio got v=%b req=%b addr=%h want 0/1/100", fetch_valid, imem_req, imem_addr); end
`ifdef FETCH_PERF_CNT_EN
        n_vec++; if (perf_flush_cnt !== 32'd2) begin n_err++; $display("FAIL flush_cnt got %0d want 2", perf_flush_cnt); end
`else
        n_vec++; if (perf_flush_cnt !== 32'd0) begin n_err++; $display("FAIL flush_cnt got %0d want 0", perf_flush_cnt); end
`endif
    endtask

    task automatic test_hold_redirect();
        imem_ack = 1'b1; imem_rdata = 32'h2222_0100;
        tick();
        imem_ack = 1'b0;
        n_vec++; if (fetch_valid !== 1'b1 || fetch_pc !== 32'h100) begin
            n_err++; $display("FAIL hold_in got v=%b pc=%h want 1/100", fetch_valid, fetch_pc); end
        redirect_valid = 1'b1; redirect_target = 32'h200; fetch_ready = 1'b1;
        tick();
        redirect_valid = 1'b0; fetch_ready = 1'b0;
        n_vec++; if (fetch_valid !== 1'b0 || imem_req !== 1'b1 || imem_addr !== 32'h200) begin
            n_err++; $display("FAIL hold_redir got v=%b req=%b addr=%h want 0/1/200", fetch_valid, imem_req, imem_addr); end
    endtask

    task automatic test_wrap();
        redirect_valid = 1'b1; redirect_target = 32'hFFFF_FFFF;
        tick();
        redirect_valid = 1'b0; imem_ack = 1'b1;
        tick();
        n_vec++; if (imem_addr !== 32'hFFFF_FFFF) begin
            n_err++; $display("FAIL wrap_top got addr=%h want ffffffff", imem_addr); end
        imem_rdata = 32'h3333_3333;
        tick();
        imem_ack = 1'b0; fetch_ready = 1'b1;
        n_vec++; if (fetch_pc !== 32'hFFFF_FFFF || fetch_valid !== 1'b1) begin
            n_err++; $display("FAIL wrap_pc got pc=%h v=%b want ffffffff/1", fetch_pc, fetch_valid); end
        tick();
        fetch_ready = 1'b0;
        n_vec++; if (imem_req !== 1'b1 || imem_addr !== 32'h0) begin
            n_err++; $display("FAIL wrap_next got req=%b addr=%h want 1/0", imem_req, imem_addr); end
    endtask

    task automatic test_stall();
        imem_ack = 1'b1; imem_rdata = 32'h4444_0000;
        tick();
        imem_ack = 1'b0;
        stall_i = 1'b1; fetch_ready = 1'b1;
        tick();
        fetch_ready = 1'b0;
        n_vec++; if (imem_req !== 1'b0 || fetch_valid !== 1'b0) begin
            n_err++; $display("FAIL stall_idle got req=%b v=%b want 0/0", imem_req, fetch_valid); end
        imem_ack = 1'b1; imem_rdata = 32'h5555_5555;
        tick();
        imem_ack = 1'b0;
        n_vec++; if (fetch_valid !== 1'b0 || imem_req !== 1'b0) begin
            n_err++; $display("FAIL idle_ack got v=%b req=%b want 0/0", fetch_valid, imem_req); end
        redirect_valid = 1'b1; redirect_target = 32'h300;
        tick();
        redirect_valid = 1'b0;
        n_vec++; if (imem_req !== 1'b0) begin n_err++; $display("FAIL stall_redir got req=%b want 0", imem_req); end
        tick(); tick();
        stall_i = 1'b0;
        tick();
        n_vec++; if (imem_req !== 1'b1 || imem_addr !== 32'h300) begin
            n_err++; $display("FAIL stall_release got req=%b addr=%h want 1/300", imem_req, imem_addr); end
`ifdef FETCH_PERF_CNT_EN
        n_vec++; if (perf_stall_cnt !== 32'd5) begin n_err++; $display("FAIL stall_cnt got %0d want 5", perf_stall_cnt); end
`else
        n_vec++; if (perf_stall_cnt !== 32'd0) begin n_err++; $display("FAIL stall_cnt got %0d want 0", perf_stall_cnt); end
`endif
    endtask

    task automatic test_midreset();
        reset_n = 1'b0;
        tick();
        n_vec++; if (imem_req !== 1'b0 || perf_stall_cnt !== 32'd0 || perf_flush_cnt !== 32'd0) begin
            n_err++; $display("FAIL midreset got req=%b cnt=%h/%h want 0/0/0", imem_req, perf_stall_cnt, perf_flush_cnt); end
        reset_n = 1'b1; imem_ack = 1'b1; imem_rdata = 32'h6666_6666;
        tick();
        imem_ack = 1'b0;
        n_vec++; if (fetch_valid !== 1'b0 || imem_req !== 1'b1 || imem_addr !== 32'h0) begin
            n_err++; $display("FAIL postreset got v=%b req=%b addr=%h want 0/1/0", fetch_valid, imem_req, imem_addr); end
    endtask

    initial begin
        test_reset();
        test_sequential();
        test_delayed_ack();
        test_redirect_flush();
        test_trap_priority();
        test_hold_redirect();
        test_wrap();
        test_stall();
        test_midreset();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
